// File: rtl/lvds_word_align_pkg.sv
// -----------------------------------------------------------------------------
// lvds_word_align_pkg
//   Shared definitions for the LVDS word aligner: the word width, the width of
//   the bit-phase counter, the aligner state encoding and a helper that sizes
//   saturating counters.
// -----------------------------------------------------------------------------
package lvds_word_align_pkg;

  localparam int LVDS_WORD_W = 8;
  localparam int BIT_CNT_W   = 3;  // counts the 8 bit phases of one word

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } align_state_t;

  // Number of bits needed to hold the values 0..max_val (at least one bit).
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/lvds_phase_cnt.sv
// -----------------------------------------------------------------------------
// lvds_phase_cnt
//   Bit-phase and word-position tracker for the word aligner.
//   bit_cnt free-runs 0..7; the cycle where it reads 7 is a word boundary, i.e.
//   the window holds a complete word.  word_cnt advances on every boundary and
//   wraps after FRAME_WORDS words.  clr restarts both counters so that the
//   first boundary falls 8 cycles after the clearing cycle.
// Ports
//   clk           in   clock
//   rst           in   asynchronous active-high reset
//   clr           in   restart the phase (asserted on the sync hit cycle)
//   boundary      out  the current window is a complete word
//   sync_boundary out  boundary where the completed word is word 0 (sync slot)
//   word_idx      out  frame position of the word completing at this boundary
// -----------------------------------------------------------------------------
module lvds_phase_cnt
  import lvds_word_align_pkg::*;
#(
  parameter int FRAME_WORDS = 2,
  localparam int WORD_CNT_W = cnt_width(FRAME_WORDS - 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  output logic                  boundary,
  output logic                  sync_boundary,
  output logic [WORD_CNT_W-1:0] word_idx
);

  localparam logic [WORD_CNT_W-1:0] LAST_WORD = WORD_CNT_W'(FRAME_WORDS - 1);

  logic [BIT_CNT_W-1:0]  bit_cnt_reg;
  logic [WORD_CNT_W-1:0] word_cnt_reg;
  logic [WORD_CNT_W-1:0] word_cnt_next;

  // word_cnt holds the position of the last completed word; the word that
  // completes at a boundary is therefore the next position.
  always_comb begin
    word_cnt_next = word_cnt_reg + WORD_CNT_W'(1);
    if (word_cnt_reg == LAST_WORD) begin
      word_cnt_next = '0;
    end
  end

  assign boundary      = (bit_cnt_reg == '1);
  assign sync_boundary = boundary && (word_cnt_next == '0);
  assign word_idx      = word_cnt_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt_reg  <= '0;
      word_cnt_reg <= '0;
    end else if (clr) begin
      bit_cnt_reg  <= '0;
      word_cnt_reg <= '0;
    end else begin
      bit_cnt_reg <= bit_cnt_reg + BIT_CNT_W'(1);
      if (boundary) begin
        word_cnt_reg <= word_cnt_next;
      end
    end
  end

endmodule

// File: rtl/lvds_word_align.sv
// -----------------------------------------------------------------------------
// lvds_word_align
//   Finds the frame sync word in the sliding window of the LVDS deserializer,
//   locks to the byte phase and emits the aligned payload words.  Isolated
//   sync misses are ridden through (flywheel); LOSS_CNT consecutive misses
//   drop lock and restart the hunt.
// Ports
//   lvds_clk  in   clock, window advances one bit per cycle
//   rst       in   asynchronous active-high reset
//   win_in    in   8-bit window, bit7 oldest, bit0 newest
//   dout      out  aligned payload word (holds when dout_vld is low)
//   dout_vld  out  one-cycle strobe, dout valid
//   dout_sof  out  with dout_vld: first payload word of the frame
//   locked    out  alignment locked
//   sync_err  out  one-cycle strobe, sync missing at a boundary while locked
// -----------------------------------------------------------------------------
module lvds_word_align
  import lvds_word_align_pkg::*;
#(
  parameter logic [LVDS_WORD_W-1:0] SYNC_WORD   = 8'hD5,
  parameter int                     FRAME_WORDS = 2,
  parameter int                     LOCK_CNT    = 3,
  parameter int                     LOSS_CNT    = 4
) (
  input  logic                   lvds_clk,
  input  logic                   rst,
  input  logic [LVDS_WORD_W-1:0] win_in,
  output logic [LVDS_WORD_W-1:0] dout,
  output logic                   dout_vld,
  output logic                   dout_sof,
  output logic                   locked,
  output logic                   sync_err
);

  localparam int WORD_CNT_W = cnt_width(FRAME_WORDS - 1);
  localparam int HIT_CNT_W  = cnt_width(LOCK_CNT);
  localparam int MISS_CNT_W = cnt_width(LOSS_CNT);

  // Counter values that, on one more event, reach the lock / loss threshold.
  localparam logic [HIT_CNT_W-1:0]  LOCK_LAST = HIT_CNT_W'(LOCK_CNT - 1);
  localparam logic [MISS_CNT_W-1:0] LOSS_LAST = MISS_CNT_W'(LOSS_CNT - 1);

  align_state_t            state_reg, state_next;
  logic [HIT_CNT_W-1:0]    hit_cnt_reg, hit_cnt_next;
  logic [MISS_CNT_W-1:0]   miss_cnt_reg, miss_cnt_next;

  logic                    sync_hit;
  logic                    cnt_clr;
  logic                    boundary;
  logic                    sync_boundary;
  logic [WORD_CNT_W-1:0]   word_idx;
  logic                    emit;
  logic                    sof_next;
  logic                    err_next;

  assign sync_hit = (win_in == SYNC_WORD);

  lvds_phase_cnt #(
    .FRAME_WORDS (FRAME_WORDS)
  ) u_phase_cnt (
    .clk           (lvds_clk),
    .rst           (rst),
    .clr           (cnt_clr),
    .boundary      (boundary),
    .sync_boundary (sync_boundary),
    .word_idx      (word_idx)
  );

  always_comb begin
    state_next    = state_reg;
    hit_cnt_next  = hit_cnt_reg;
    miss_cnt_next = miss_cnt_reg;
    cnt_clr       = 1'b0;
    emit          = 1'b0;
    sof_next      = 1'b0;
    err_next      = 1'b0;

    unique case (state_reg)
      HUNT: begin
        // The first matching window wins, even if the sync word aliases at
        // other phases; the hit word becomes word 0 of the frame.
        if (sync_hit) begin
          cnt_clr       = 1'b1;
          hit_cnt_next  = HIT_CNT_W'(1);
          miss_cnt_next = '0;
          state_next    = (LOCK_CNT == 1) ? LOCKED : VERIFY;
        end
      end

      VERIFY: begin
        // Only sync slots matter here; payload is not trusted yet.
        if (sync_boundary) begin
          if (sync_hit) begin
            hit_cnt_next = hit_cnt_reg + HIT_CNT_W'(1);
            if (hit_cnt_reg == LOCK_LAST) begin
              state_next = LOCKED;
            end
          end else begin
            hit_cnt_next = '0;
            state_next   = HUNT;
          end
        end
      end

      LOCKED: begin
        if (boundary && !sync_boundary) begin
          emit     = 1'b1;
          sof_next = (word_idx == WORD_CNT_W'(1));
        end
        if (sync_boundary) begin
          if (sync_hit) begin
            miss_cnt_next = '0;
          end else begin
            // Flywheel: flag the miss but keep the phase until the
            // consecutive-miss limit is reached.
            err_next = 1'b1;
            if (miss_cnt_reg == LOSS_LAST) begin
              miss_cnt_next = '0;
              hit_cnt_next  = '0;
              state_next    = HUNT;
            end else begin
              miss_cnt_next = miss_cnt_reg + MISS_CNT_W'(1);
            end
          end
        end
      end

      default: begin
        state_next = HUNT;
      end
    endcase
  end

  always_ff @(posedge lvds_clk or posedge rst) begin
    if (rst) begin
      state_reg    <= HUNT;
      hit_cnt_reg  <= '0;
      miss_cnt_reg <= '0;
      dout         <= '0;
      dout_vld     <= 1'b0;
      dout_sof     <= 1'b0;
      locked       <= 1'b0;
      sync_err     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      hit_cnt_reg  <= hit_cnt_next;
      miss_cnt_reg <= miss_cnt_next;
      locked       <= (state_next == LOCKED);
      dout_vld     <= emit;
      dout_sof     <= sof_next;
      sync_err     <= err_next;
      if (emit) begin
        dout <= win_in;
      end
    end
  end

endmodule

// File: tb/tb_lvds_word_align.sv
// -----------------------------------------------------------------------------
// tb_lvds_word_align
//   Directed bench for lvds_word_align.  A bit serializer drives a reference
//   shift register (MSB of each byte first) into two aligners: FRAME_WORDS=2
//   (dut) and FRAME_WORDS=4 (dut4).  A monitor logs every output event with the
//   clock edge it appeared on; the expected edges come from the edges at which
//   the bench completed each byte of the stream.
// -----------------------------------------------------------------------------
module tb_lvds_word_align;

  localparam int K_VLD    = 0;
  localparam int K_ERR    = 1;
  localparam int K_RISE   = 2;
  localparam int K_FALL   = 3;
  localparam int K_SOFBAD = 4;

  typedef struct {
    int         id;
    int         at;
    int         kind;
    logic [7:0] d;
    logic       sof;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] win_in = 8'h00;

  logic [7:0] a_dout, b_dout;
  logic       a_vld, a_sof, a_locked, a_err;
  logic       b_vld, b_sof, b_locked, b_err;

  int   cyc = 0;
  int   last_edge = 0;
  ev_t  ev_q[$];
  logic lk_q [2] = '{1'b0, 1'b0};

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  lvds_word_align #(
    .SYNC_WORD   (8'hD5),
    .FRAME_WORDS (2),
    .LOCK_CNT    (3),
    .LOSS_CNT    (4)
  ) dut (
    .lvds_clk (clk),
    .rst      (rst),
    .win_in   (win_in),
    .dout     (a_dout),
    .dout_vld (a_vld),
    .dout_sof (a_sof),
    .locked   (a_locked),
    .sync_err (a_err)
  );

  lvds_word_align #(
    .SYNC_WORD   (8'hD5),
    .FRAME_WORDS (4),
    .LOCK_CNT    (3),
    .LOSS_CNT    (4)
  ) dut4 (
    .lvds_clk (clk),
    .rst      (rst),
    .win_in   (win_in),
    .dout     (b_dout),
    .dout_vld (b_vld),
    .dout_sof (b_sof),
    .locked   (b_locked),
    .sync_err (b_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic log_dut(input int id, input logic [7:0] d, input logic v, input logic s,
                         input logic e, input logic l);
    if (v) begin
      ev_q.push_back('{id: id, at: cyc, kind: K_VLD, d: d, sof: s});
      $display("[tb] dut%0d edge %0d dout=%02h sof=%0b", id, cyc, d, s);
    end
    if (s && !v) ev_q.push_back('{id: id, at: cyc, kind: K_SOFBAD, d: d, sof: s});
    if (e)       ev_q.push_back('{id: id, at: cyc, kind: K_ERR, d: d, sof: s});
    if (l === 1'b1 && lk_q[id] == 1'b0) ev_q.push_back('{id: id, at: cyc, kind: K_RISE, d: d, sof: s});
    if (l === 1'b0 && lk_q[id] == 1'b1) ev_q.push_back('{id: id, at: cyc, kind: K_FALL, d: d, sof: s});
    lk_q[id] = (l === 1'b1);
  endtask

  // Edge counter and output monitor; samples 1 time unit after each edge.
  always @(posedge clk) begin
    cyc++;
    #1;
    log_dut(0, a_dout, a_vld, a_sof, a_err, a_locked);
    log_dut(1, b_dout, b_vld, b_sof, b_err, b_locked);
  end

  function automatic int ev_count(input int id, input int kind, input int lo, input int hi);
    int n = 0;
    foreach (ev_q[i])
      if (ev_q[i].id == id && ev_q[i].kind == kind && ev_q[i].at >= lo && ev_q[i].at <= hi) n++;
    return n;
  endfunction

  function automatic int ev_count_d(input int id, input int lo, input int hi, input logic [7:0] d,
                                    input bit sof_only);
    int n = 0;
    foreach (ev_q[i])
      if (ev_q[i].id == id && ev_q[i].kind == K_VLD && ev_q[i].at >= lo && ev_q[i].at <= hi &&
          ev_q[i].d == d && (!sof_only || ev_q[i].sof)) n++;
    return n;
  endfunction

  function automatic int ev_count_sof(input int id, input int lo, input int hi);
    int n = 0;
    foreach (ev_q[i])
      if (ev_q[i].id == id && ev_q[i].kind == K_VLD && ev_q[i].at >= lo && ev_q[i].at <= hi &&
          ev_q[i].sof) n++;
    return n;
  endfunction

  function automatic int ev_first(input int id, input int kind, input int lo, input int hi);
    foreach (ev_q[i])
      if (ev_q[i].id == id && ev_q[i].kind == kind && ev_q[i].at >= lo && ev_q[i].at <= hi)
        return ev_q[i].at;
    return -1;
  endfunction

  function automatic int ev_last(input int id, input int kind, input int lo, input int hi);
    int r = -1;
    foreach (ev_q[i])
      if (ev_q[i].id == id && ev_q[i].kind == kind && ev_q[i].at >= lo && ev_q[i].at <= hi)
        r = ev_q[i].at;
    return r;
  endfunction

  // One serial bit; records the clock edge that will sample it.
  task automatic send_bit(input logic b);
    @(negedge clk);
    win_in    = {win_in[6:0], b};
    last_edge = cyc + 1;
  endtask

  task automatic send_byte(input logic [7:0] v, output int at);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
    at = last_edge;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_dout"},     {24'd0, a_dout},  32'd0);
    check({tag, "_dout_vld"}, {31'd0, a_vld},   32'd0);
    check({tag, "_dout_sof"}, {31'd0, a_sof},   32'd0);
    check({tag, "_locked"},   {31'd0, a_locked}, 32'd0);
    check({tag, "_sync_err"}, {31'd0, a_err},   32'd0);
  endtask

  initial begin
    int d5e[8], c3e[8];
    int e5d[8], e5c[8];
    int f3d[4], f3c[4];
    int g[5][4];
    int at, first_d4, slip, fe, lo, hi;
    logic [7:0] sb;
    logic [7:0] pay4 [4];

    pay4[0] = 8'hD5; pay4[1] = 8'h11; pay4[2] = 8'h22; pay4[3] = 8'h33;

    // ---- 1: reset with random window
    repeat (4) begin
      @(negedge clk);
      win_in = 8'($urandom);
    end
    @(negedge clk);
    check_zero("t1_rst");
    check("t1_rst_dut4_locked", {31'd0, b_locked}, 32'd0);
    win_in = 8'h00;
    rst    = 1'b0;

    // ---- 2: lock on {D5,3C} frames after 5 junk bits
    lo = cyc + 1;
    repeat (5) send_bit(1'b0);
    for (int f = 0; f < 8; f++) begin
      send_byte(8'hD5, d5e[f]);
      send_byte(8'h3C, c3e[f]);
    end

    // ---- 4: flywheel, D4 in place of the sync in 3 frames, twice
    for (int f = 0; f < 9; f++) begin
      sb = (f == 3 || f >= 7) ? 8'hD5 : 8'hD4;
      send_byte(sb, at);
      if (f == 0) first_d4 = at;
      send_byte(8'h3C, at);
    end
    hi = at;

    // ---- 5: one-bit phase slip, loss and relock
    send_bit(1'b0);
    slip = last_edge;
    for (int f = 0; f < 8; f++) begin
      send_byte(8'hD5, e5d[f]);
      send_byte(8'h3C, e5c[f]);
    end

    // ---- 1b: reset while locked clears outputs at once
    @(negedge clk);
    check("t5_locked_end", {31'd0, a_locked}, 32'd1);
    check("t5_vld_end",    {31'd0, a_vld},    32'd1);
    check("t5_dout_end",   {24'd0, a_dout},   32'h3C);
    rst = 1'b1;
    #1;
    check_zero("t1_midrst");

    // test 2 results
    check("t2_lock_edge",   ev_first(0, K_RISE, lo, c3e[7]), d5e[2]);
    check("t2_vld_count",   ev_count(0, K_VLD, lo, c3e[7]), 6);
    check("t2_vld_3c",      ev_count_d(0, lo, c3e[7], 8'h3C, 1'b0), 6);
    check("t2_sof_count",   ev_count_sof(0, lo, c3e[7]), 6);
    check("t2_first_vld",   ev_first(0, K_VLD, lo, c3e[7]), c3e[2]);
    check("t2_last_vld",    ev_last(0, K_VLD, lo, c3e[7]), c3e[7]);
    check("t2_sync_err",    ev_count(0, K_ERR, lo, c3e[7]), 0);

    // test 4 results
    lo = c3e[7] + 1;
    check("t4_err_count",   ev_count(0, K_ERR, lo, hi), 6);
    check("t4_first_err",   ev_first(0, K_ERR, lo, hi), first_d4);
    check("t4_lock_fall",   ev_count(0, K_FALL, lo, hi), 0);
    check("t4_vld_3c",      ev_count_d(0, lo, hi, 8'h3C, 1'b1), 9);
    check("t4_vld_count",   ev_count(0, K_VLD, lo, hi), 9);

    // test 5 results: misses at slip+7+16k, flywheel payload reads 9E
    hi = e5c[7];
    check("t5_err_count",   ev_count(0, K_ERR, slip, hi), 4);
    check("t5_first_err",   ev_first(0, K_ERR, slip, hi), slip + 7);
    check("t5_lock_fall",   ev_first(0, K_FALL, slip, hi), slip + 55);
    check("t5_vld_9e",      ev_count_d(0, slip, slip + 55, 8'h9E, 1'b0), 3);
    check("t5_relock_edge", ev_first(0, K_RISE, slip, hi), e5d[5]);
    check("t5_vld_3c",      ev_count_d(0, slip, hi, 8'h3C, 1'b0), 3);
    check("t5_first_3c",    ev_first(0, K_VLD, slip + 56, hi), e5c[5]);
    check("t5_vld_count",   ev_count(0, K_VLD, slip, hi), 6);

    // ---- 3: false sync, then a real stream
    repeat (2) @(negedge clk);
    win_in = 8'h00;
    rst    = 1'b0;
    lo     = cyc + 1;
    send_byte(8'hD5, fe);
    repeat (4) send_byte(8'h00, at);
    for (int f = 0; f < 4; f++) begin
      send_byte(8'hD5, f3d[f]);
      send_byte(8'h3C, f3c[f]);
    end
    hi = f3c[3];
    @(negedge clk);
    rst = 1'b1;
    check("t3_no_lock_false", ev_count(0, K_RISE, lo, f3d[1]), 0);
    check("t3_no_vld_false",  ev_count(0, K_VLD, lo, f3d[2]), 0);
    check("t3_lock_edge",     ev_first(0, K_RISE, lo, hi), f3d[2]);
    check("t3_vld_count",     ev_count(0, K_VLD, lo, hi), 2);
    check("t3_sync_err",      ev_count(0, K_ERR, lo, hi), 0);

    // ---- 6: FRAME_WORDS=4, frames {D5,11,22,33}
    repeat (2) @(negedge clk);
    win_in = 8'h00;
    rst    = 1'b0;
    lo     = cyc + 1;
    for (int f = 0; f < 5; f++)
      for (int w = 0; w < 4; w++)
        send_byte(pay4[w], g[f][w]);
    hi = g[4][3];
    @(negedge clk);
    check("t6_lock_edge",   ev_first(1, K_RISE, lo, hi), g[2][0]);
    check("t6_vld_count",   ev_count(1, K_VLD, lo, hi), 9);
    check("t6_first_vld",   ev_first(1, K_VLD, lo, hi), g[2][1]);
    check("t6_last_vld",    ev_last(1, K_VLD, lo, hi), g[4][3]);
    check("t6_vld_11",      ev_count_d(1, lo, hi, 8'h11, 1'b0), 3);
    check("t6_vld_22",      ev_count_d(1, lo, hi, 8'h22, 1'b0), 3);
    check("t6_vld_33",      ev_count_d(1, lo, hi, 8'h33, 1'b0), 3);
    check("t6_sof_count",   ev_count_sof(1, lo, hi), 3);
    check("t6_sof_on_11",   ev_count_d(1, lo, hi, 8'h11, 1'b1), 3);
    check("t6_vld_gap",     ev_first(1, K_VLD, g[2][1] + 1, hi), g[2][2]);
    check("t6_sync_err",    ev_count(1, K_ERR, lo, hi), 0);

    // strobes must never show sof without vld
    check("sof_without_vld_a", ev_count(0, K_SOFBAD, 0, cyc), 0);
    check("sof_without_vld_b", ev_count(1, K_SOFBAD, 0, cyc), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
